uimac_pause_frame_gen: RTL and testbench

- Transmit-side MAC control block. It builds and sends IEEE 802.3x PAUSE frames as a byte stream into the MAC TX arbiter.
- It is the far end of the RX pause parser: the local receive path uses it to ask the link partner to stop sending (quanta > 0, XOFF) or resume (quanta = 0, XON).
- Output covers DA through pad only. The downstream MAC TX path adds preamble/SFD and FCS.

---
 rtl/uimac_pkg.sv | 19 +
 rtl/uimac_pause_byte_mux.sv | 39 +++
 rtl/uimac_pause_frame_gen.sv | 153 +++++++++++++++
 tb/tb_uimac_pause_frame_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/uimac_pkg.sv
// Shared MAC-control constants and FSM encoding for the uimac pause TX and RX blocks.
package uimac_pkg;

  localparam logic [47:0] PAUSE_DA          = 48'h0180C2000001;
  localparam logic [15:0] ETH_TYPE_MAC_CTRL = 16'h8808;
  localparam logic [15:0] PAUSE_OPCODE      = 16'h0001;
  localparam int unsigned MIN_FRAME_NOFCS   = 32'd60;

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_ARB_ENC  = 2'd1;
  localparam logic [1:0] ST_SEND_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_ARB  = ST_ARB_ENC,
    ST_SEND = ST_SEND_ENC
  } pfg_state_e;

endpackage

// File: rtl/uimac_pause_byte_mux.sv
// Combinational selector of one PAUSE frame byte (DA..pad) for a given byte index.
module uimac_pause_byte_mux #(
  parameter logic [47:0] PAUSE_DA     = uimac_pkg::PAUSE_DA,
  parameter logic [15:0] ETH_TYPE     = uimac_pkg::ETH_TYPE_MAC_CTRL,
  parameter logic [15:0] PAUSE_OPCODE = uimac_pkg::PAUSE_OPCODE
) (
  input  logic [5:0]  idx,
  input  logic [47:0] src_mac,
  input  logic [15:0] quanta,
  output logic [7:0]  byte_out
);

  // Byte lookup by index; everything past the quanta field is zero pad.
  always_comb begin
    byte_out = 8'h00;
    case (idx)
      6'd0:    byte_out = PAUSE_DA[47:40];
      6'd1:    byte_out = PAUSE_DA[39:32];
      6'd2:    byte_out = PAUSE_DA[31:24];
      6'd3:    byte_out = PAUSE_DA[23:16];
      6'd4:    byte_out = PAUSE_DA[15:8];
      6'd5:    byte_out = PAUSE_DA[7:0];
      6'd6:    byte_out = src_mac[47:40];
      6'd7:    byte_out = src_mac[39:32];
      6'd8:    byte_out = src_mac[31:24];
      6'd9:    byte_out = src_mac[23:16];
      6'd10:   byte_out = src_mac[15:8];
      6'd11:   byte_out = src_mac[7:0];
      6'd12:   byte_out = ETH_TYPE[15:8];
      6'd13:   byte_out = ETH_TYPE[7:0];
      6'd14:   byte_out = PAUSE_OPCODE[15:8];
      6'd15:   byte_out = PAUSE_OPCODE[7:0];
      6'd16:   byte_out = quanta[15:8];
      6'd17:   byte_out = quanta[7:0];
      default: byte_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/uimac_pause_frame_gen.sv
// Transmit-side 802.3x PAUSE frame generator: arbitrates for the TX slot and streams DA..pad bytes.
module uimac_pause_frame_gen #(
  parameter int unsigned FRAME_LEN    = uimac_pkg::MIN_FRAME_NOFCS,
  parameter logic [47:0] PAUSE_DA     = uimac_pkg::PAUSE_DA,
  parameter logic [15:0] ETH_TYPE     = uimac_pkg::ETH_TYPE_MAC_CTRL,
  parameter logic [15:0] PAUSE_OPCODE = uimac_pkg::PAUSE_OPCODE
) (
  input  logic        I_clk,
  input  logic        I_reset,
  input  logic        I_pause_req,
  input  logic [15:0] I_pause_quanta,
  input  logic [47:0] I_src_mac,
  output logic        O_tx_req,
  input  logic        I_tx_grant,
  output logic        O_mac_valid,
  output logic [7:0]  O_mac_data,
  output logic        O_mac_last,
  input  logic        I_mac_ready,
  output logic        O_busy,
  output logic        O_done
);

  import uimac_pkg::*;

  localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 32'd1);

  pfg_state_e  state_r;
  logic [5:0]  cnt_r;
  logic [15:0] quanta_r;
  logic [47:0] sa_r;
  logic        pend_r;
  logic [15:0] pend_quanta_r;
  logic [47:0] pend_sa_r;

  logic        accept_s;
  logic        last_accept_s;
  logic [5:0]  mux_idx_s;
  logic [7:0]  byte_s;

  assign accept_s      = O_mac_valid & I_mac_ready;
  assign last_accept_s = accept_s & (cnt_r == LAST_IDX);

  // Data is registered, so the mux looks one byte ahead of the counter.
  always_comb begin
    mux_idx_s = 6'd0;
    if (state_r == ST_SEND) begin
      mux_idx_s = cnt_r + 6'd1;
    end else begin
      mux_idx_s = 6'd0;
    end
  end

  uimac_pause_byte_mux #(
    .PAUSE_DA     (PAUSE_DA),
    .ETH_TYPE     (ETH_TYPE),
    .PAUSE_OPCODE (PAUSE_OPCODE)
  ) u_byte_mux (
    .idx      (mux_idx_s),
    .src_mac  (sa_r),
    .quanta   (quanta_r),
    .byte_out (byte_s)
  );

  // Control FSM with registered outputs, active/pending snapshots and byte counter.
  always_ff @(posedge I_clk) begin
    if (I_reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= 6'd0;
      quanta_r      <= 16'd0;
      sa_r          <= 48'd0;
      pend_r        <= 1'b0;
      pend_quanta_r <= 16'd0;
      pend_sa_r     <= 48'd0;
      O_tx_req      <= 1'b0;
      O_mac_valid   <= 1'b0;
      O_mac_data    <= 8'h00;
      O_mac_last    <= 1'b0;
      O_busy        <= 1'b0;
      O_done        <= 1'b0;
    end else begin
      O_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (I_pause_req) begin
            quanta_r <= I_pause_quanta;
            sa_r     <= I_src_mac;
            state_r  <= ST_ARB;
            O_tx_req <= 1'b1;
            O_busy   <= 1'b1;
          end
        end
        ST_ARB: begin
          if (I_pause_req) begin
            pend_r        <= 1'b1;
            pend_quanta_r <= I_pause_quanta;
            pend_sa_r     <= I_src_mac;
          end
          if (I_tx_grant) begin
            O_tx_req    <= 1'b0;
            state_r     <= ST_SEND;
            cnt_r       <= 6'd0;
            O_mac_valid <= 1'b1;
            O_mac_data  <= byte_s;
            O_mac_last  <= (LAST_IDX == 6'd0);
          end
        end
        ST_SEND: begin
          if (last_accept_s) begin
            O_mac_valid <= 1'b0;
            O_mac_data  <= 8'h00;
            O_mac_last  <= 1'b0;
            O_done      <= 1'b1;
            cnt_r       <= 6'd0;
            pend_r      <= 1'b0;
            // A request coinciding with the last byte is newer than any stored one.
            if (I_pause_req) begin
              quanta_r <= I_pause_quanta;
              sa_r     <= I_src_mac;
              state_r  <= ST_ARB;
              O_tx_req <= 1'b1;
            end else if (pend_r) begin
              quanta_r <= pend_quanta_r;
              sa_r     <= pend_sa_r;
              state_r  <= ST_ARB;
              O_tx_req <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
              O_busy  <= 1'b0;
            end
          end else begin
            if (I_pause_req) begin
              pend_r        <= 1'b1;
              pend_quanta_r <= I_pause_quanta;
              pend_sa_r     <= I_src_mac;
            end
            if (accept_s) begin
              cnt_r      <= cnt_r + 6'd1;
              O_mac_data <= byte_s;
              O_mac_last <= ((cnt_r + 6'd1) == LAST_IDX);
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          O_tx_req    <= 1'b0;
          O_mac_valid <= 1'b0;
          O_busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uimac_pause_frame_gen.sv
// Directed self-checking bench for uimac_pause_frame_gen (60-byte and 64-byte instances).
module tb_uimac_pause_frame_gen;

  localparam logic [47:0] SA1 = 48'h001122334455;
  localparam logic [47:0] SA2 = 48'hA0B1C2D3E4F5;

  logic        clk = 1'b0;
  logic        reset, req, grant, ready, sel64;
  logic [15:0] quanta;
  logic [47:0] sa;

  logic        req_a, req_b;
  logic        tx_req_a, valid_a, last_a, busy_a, done_a;
  logic        tx_req_b, valid_b, last_b, busy_b, done_b;
  logic [7:0]  data_a, data_b;
  logic        tx_req, valid, last, busy, done;
  logic [7:0]  data;

  int total = 0;
  int bad   = 0;
  int ncyc;

  always #5 clk = ~clk;

  assign req_a  = req & ~sel64;
  assign req_b  = req & sel64;
  assign tx_req = sel64 ? tx_req_b : tx_req_a;
  assign valid  = sel64 ? valid_b  : valid_a;
  assign data   = sel64 ? data_b   : data_a;
  assign last   = sel64 ? last_b   : last_a;
  assign busy   = sel64 ? busy_b   : busy_a;
  assign done   = sel64 ? done_b   : done_a;

  uimac_pause_frame_gen u_dut_a (
    .I_clk(clk), .I_reset(reset), .I_pause_req(req_a), .I_pause_quanta(quanta),
    .I_src_mac(sa), .O_tx_req(tx_req_a), .I_tx_grant(grant), .O_mac_valid(valid_a),
    .O_mac_data(data_a), .O_mac_last(last_a), .I_mac_ready(ready),
    .O_busy(busy_a), .O_done(done_a)
  );

  uimac_pause_frame_gen #(.FRAME_LEN(32'd64)) u_dut_b (
    .I_clk(clk), .I_reset(reset), .I_pause_req(req_b), .I_pause_quanta(quanta),
    .I_src_mac(sa), .O_tx_req(tx_req_b), .I_tx_grant(grant), .O_mac_valid(valid_b),
    .O_mac_data(data_b), .O_mac_last(last_b), .I_mac_ready(ready),
    .O_busy(busy_b), .O_done(done_b)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int i, input logic [47:0] s, input logic [15:0] q);
    logic [143:0] hdr;
    hdr = {48'h0180C2000001, s, 16'h8808, 16'h0001, q};
    if (i < 18) return hdr[143 - 8*i -: 8];
    return 8'h00;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [15:0] q, input logic [47:0] s);
    req = 1'b1; quanta = q; sa = s;
    step();
    req = 1'b0;
    check_val("req_busy_txreq", {busy, tx_req}, 64'h3);
  endtask

  task automatic grant_after(input int n);
    repeat (n) begin
      step();
      check_val("arb_hold", {tx_req, valid}, 64'h2);
    end
    grant = 1'b1;
    step();
    grant = 1'b0;
    check_val("grant_start", {tx_req, valid}, 64'h1);
  endtask

  task automatic collect(input int flen, input logic [47:0] s, input logic [15:0] q, input bit tog,
                         input int inj_idx, input logic [15:0] inj_q, input logic [47:0] inj_sa,
                         input int abort_idx, input bit exp_busy, output int cyc);
    int idx = 0;
    int guard = 0;
    bit rdy = 1'b1;
    bit injected = 1'b0;
    cyc = 0;
    while (idx < flen && guard < 400) begin
      if (idx == abort_idx) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_val("reset_outs", {tx_req, valid, data, last, busy, done}, 64'd0);
        ready = 1'b1;
        return;
      end
      check_val("valid", {63'd0, valid}, 64'd1);
      check_val("byte_last", {data, last}, {exp_byte(idx, s, q), idx == flen - 1});
      ready = rdy;
      if (idx == inj_idx && !injected) begin
        req = 1'b1; quanta = inj_q; sa = inj_sa; injected = 1'b1;
      end
      cyc++;
      step();
      req = 1'b0;
      if (rdy) idx++;
      if (tog) rdy = ~rdy;
      guard++;
    end
    ready = 1'b1;
    check_val("frame_len", idx, flen);
    check_val("end_state", {valid, last, done, busy}, {60'd0, 1'b0, 1'b0, 1'b1, exp_busy});
    step();
    check_val("done_pulse", {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic seen;
    reset = 1'b1; req = 1'b0; grant = 1'b0; ready = 1'b1; sel64 = 1'b0;
    quanta = 16'd0; sa = 48'd0;
    step(); step();
    check_val("reset_a", {tx_req_a, valid_a, data_a, last_a, busy_a, done_a}, 64'd0);
    check_val("reset_b", {tx_req_b, valid_b, data_b, last_b, busy_b, done_b}, 64'd0);
    reset = 1'b0;
    step();

    // Stray grant in IDLE does nothing
    grant = 1'b1; step(); grant = 1'b0;
    check_val("idle_grant", {tx_req, valid, busy}, 64'd0);

    // Basic frame, ready always high
    send_req(16'h0400, SA1);
    grant_after(3);
    collect(60, SA1, 16'h0400, 1'b0, -1, 16'd0, 48'd0, -1, 1'b0, ncyc);
    check_val("basic_cycles", ncyc, 64'd60);

    // Ready toggling 1/0: 119 cycles from first valid
    send_req(16'h0400, SA1);
    grant_after(1);
    collect(60, SA1, 16'h0400, 1'b1, -1, 16'd0, 48'd0, -1, 1'b0, ncyc);
    check_val("stall_cycles", ncyc, 64'd119);

    // XON frame, with a request coinciding with last-byte acceptance
    send_req(16'h0000, SA1);
    grant_after(2);
    collect(60, SA1, 16'h0000, 1'b0, 59, 16'h0300, SA2, -1, 1'b1, ncyc);
    check_val("chain_txreq", {tx_req, busy}, 64'h3);
    grant_after(1);
    collect(60, SA2, 16'h0300, 1'b0, -1, 16'd0, 48'd0, -1, 1'b0, ncyc);

    // Pending requests during ARB and SEND, latest wins
    send_req(16'h0010, SA1);
    req = 1'b1; quanta = 16'h0015; sa = SA2;
    step();
    req = 1'b0;
    grant_after(1);
    collect(60, SA1, 16'h0010, 1'b0, 30, 16'h0020, SA2, -1, 1'b1, ncyc);
    check_val("pend_txreq", {tx_req, busy}, 64'h3);
    grant_after(2);
    collect(60, SA2, 16'h0020, 1'b0, -1, 16'd0, 48'd0, -1, 1'b0, ncyc);
    seen = 1'b0;
    repeat (10) begin
      step();
      seen = seen | tx_req | valid | busy;
    end
    check_val("only_two_frames", {63'd0, seen}, 64'd0);

    // Reset at byte 25 with a pending request: no done, pending dropped
    send_req(16'h0400, SA1);
    grant_after(0);
    collect(60, SA1, 16'h0400, 1'b0, 10, 16'h0055, SA2, 25, 1'b0, ncyc);
    seen = 1'b0;
    repeat (5) begin
      step();
      seen = seen | done | tx_req | valid;
    end
    check_val("post_reset_quiet", {63'd0, seen}, 64'd0);
    send_req(16'h0400, SA1);
    grant_after(2);
    collect(60, SA1, 16'h0400, 1'b0, -1, 16'd0, 48'd0, -1, 1'b0, ncyc);

    // FRAME_LEN = 64 instance
    sel64 = 1'b1;
    send_req(16'h1234, SA2);
    grant_after(1);
    collect(64, SA2, 16'h1234, 1'b0, -1, 16'd0, 48'd0, -1, 1'b0, ncyc);
    check_val("len64_cycles", ncyc, 64'd64);
    sel64 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
